jala_sequencer: RTL and testbench
=================================

# jala_sequencer

Multicycle control FSM for the JALA stage-5 integrated datapath (PC, MSP, RSP incrementers plus dual-port memory access with ValA/ValB/IR latches). It fetches and decodes each instruction, then drives every datapath write-enable, mux select and register reset for that instruction's data path. It sits between the integrated datapath's control inputs and the top level, and exposes run/halt status.

## Interface
- No parameters.
- CLK  in  1  system clock; all state changes on rising edge
- RegResetN  in  1  asynchronous, active-low reset
- Run  in  1  permits a new fetch; sampled in FETCH only
- IROut  in  16  current instruction; opcode = IROut[15:12]
- MSPWrite, MSPop, MSPRegReset  out  1 each  MSP control (Op 0 = +1, 1 = −1)
- RSPWrite, RSPop, RSPRegReset  out  1 each  RSP control (same Op encoding)
- PCWrite, PCSource, PCAdd, PCRegReset  out  1 each  PC control (PCSource 1 = load ValA; else PC + (PCAdd ? SignExt : 1))
- ValAWrite, ValBWrite, IRWrite  out  1 each  latch enables (ValA ← port-2 read data; ValB, IR ← port-1 read data)
- MemRead1, MemRead2, MemWrite1, MemWrite2  out  1 each  memory port strobes
- MemDst1  out  2  0 = PC, 1 = MSP
- MemDst2  out  2  0 = MSP, 1 = RSP
- MemData  out  2  0 = PC, 1 = Res, 2 = ZEImm
- Halted  out  1  high in HALT
- IllegalOp  out  1  one-cycle pulse in DECODE for an undefined opcode
- State  out  4  current state encoding (debug)

## Operation
- States: INIT, FETCH, DECODE, PUSH, ALU_D, ALU_RA, ALU_RB, ALU_WB, JMP, CALL, RET_D, RET_R, RET_J, HALT.
- Every strobe/enable defaults to 0 and every select to 0 unless listed for the current state.
- INIT: assert PCRegReset, MSPRegReset, RSPRegReset → FETCH.
- FETCH: if Run=0, hold with all outputs at default. If Run=1: MemDst1=0, MemRead1, IRWrite, PCWrite (PCSource=0, PCAdd=0) → DECODE.
- DECODE on opcode: 0 NOP → FETCH; 1 PUSHI → PUSH; 2 ALU → ALU_D; 3 JMP → JMP; 4 CALL → CALL; 5 RET → RET_D; F HALT → HALT; 6–E → IllegalOp pulse, → FETCH.
- PUSH: MemDst2=0, MemData=2, MemWrite2, MSPWrite, MSPop=0 → FETCH.
- ALU_D: MSPWrite, MSPop=1 → ALU_RA.
- ALU_RA: MemDst2=0, MemRead2, ValAWrite, MSPWrite, MSPop=1 → ALU_RB.
- ALU_RB: MemDst1=1, MemRead1, ValBWrite → ALU_WB.
- ALU_WB: MemDst2=0, MemData=1, MemWrite2, MSPWrite, MSPop=0 → FETCH. Res is combinational from ValA/ValB and is valid in this cycle.
- JMP: PCWrite, PCSource=0, PCAdd=1 → FETCH.
- CALL: MemDst2=1, MemData=0, MemWrite2, RSPWrite, RSPop=0, PCWrite, PCSource=0, PCAdd=1 → FETCH. The stored PC is the already-incremented return address.
- RET_D: RSPWrite, RSPop=1 → RET_R.
- RET_R: MemDst2=1, MemRead2, ValAWrite → RET_J.
- RET_J: PCWrite, PCSource=1 → FETCH.
- HALT: Halted=1. The FSM stays in HALT until reset.
- Stack convention: MSP and RSP point at the next free word. Push writes, then increments. Pop decrements, then reads.
- MemWrite1 is never asserted.

## Timing
- Asynchronous reset: state = INIT and all outputs at default immediately. INIT runs on the first edge after RegResetN rises.
- Assertion of RegResetN mid-instruction aborts the instruction at once. No partial write is issued after assertion.
- Control outputs are Moore outputs: decoded from state, plus IROut in DECODE only.
- Datapath registers update on the same edge that leaves the state driving them.
- Cycles per instruction, counted FETCH to next FETCH: NOP 2, illegal 2, PUSHI 3, JMP 3, CALL 3, ALU 6, RET 5.
- Run=0 stalls only at an instruction boundary. An instruction in progress always completes.
- MSP/RSP wrap modulo 2^16 in the datapath. The sequencer does not check overflow or underflow.

## Test plan
- Reset: hold RegResetN=0 for 3 cycles, then release → State=INIT for one cycle with all three RegResets=1, then FETCH; PC=MSP=RSP=0.
- PUSHI: IR=0x1005, then PUSHI 0x0003, then ALU (Res=ValA+ValB) → ValA=3, ValB=5, mem[0]=8, MSP=1; ALU takes exactly 6 cycles.
- Control flow: CALL to +4 at PC=2 → mem[RSP0]=3, RSP=1, PC=7. RET there → PC=3, RSP=0, 5 cycles.
- Stall and illegal op: Run=0 in FETCH for 10 cycles → no strobes and PC unchanged. Opcode 0x7 → IllegalOp high exactly 1 cycle, PC advances by 1.
- Halt and async reset: HALT → Halted=1 held for 20 cycles. Separately, drop RegResetN during ALU_RA → all outputs 0 in the same cycle and no MemWrite2 occurs.

Source files
------------

// File: rtl/jala_sequencer.sv
// Multicycle control FSM for the JALA stage-5 datapath: fetch, decode and
// per-instruction sequencing of every datapath enable, select and register reset.
module jala_sequencer (
  input  logic        CLK,
  input  logic        RegResetN,
  input  logic        Run,
  input  logic [15:0] IROut,
  output logic        MSPWrite,
  output logic        MSPop,
  output logic        MSPRegReset,
  output logic        RSPWrite,
  output logic        RSPop,
  output logic        RSPRegReset,
  output logic        PCWrite,
  output logic        PCSource,
  output logic        PCAdd,
  output logic        PCRegReset,
  output logic        ValAWrite,
  output logic        ValBWrite,
  output logic        IRWrite,
  output logic        MemRead1,
  output logic        MemRead2,
  output logic        MemWrite1,
  output logic        MemWrite2,
  output logic [1:0]  MemDst1,
  output logic [1:0]  MemDst2,
  output logic [1:0]  MemData,
  output logic        Halted,
  output logic        IllegalOp,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_PUSH   = 4'd3,
    S_ALU_D  = 4'd4,
    S_ALU_RA = 4'd5,
    S_ALU_RB = 4'd6,
    S_ALU_WB = 4'd7,
    S_JMP    = 4'd8,
    S_CALL   = 4'd9,
    S_RET_D  = 4'd10,
    S_RET_R  = 4'd11,
    S_RET_J  = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  opcode;
  logic        unused_imm;

  assign opcode     = IROut[15:12];
  // The immediate field is consumed by the datapath, not by the sequencer.
  assign unused_imm = ^IROut[11:0];
  assign State      = state_q;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RegResetN) begin
    if (!RegResetN) state_q <= S_INIT;
    else            state_q <= state_d;
  end

  // NOTE: every output and state_d gets a default before the case, so no
  // path through this block leaves a signal unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    MSPWrite    = 1'b0;
    MSPop       = 1'b0;
    MSPRegReset = 1'b0;
    RSPWrite    = 1'b0;
    RSPop       = 1'b0;
    RSPRegReset = 1'b0;
    PCWrite     = 1'b0;
    PCSource    = 1'b0;
    PCAdd       = 1'b0;
    PCRegReset  = 1'b0;
    ValAWrite   = 1'b0;
    ValBWrite   = 1'b0;
    IRWrite     = 1'b0;
    MemRead1    = 1'b0;
    MemRead2    = 1'b0;
    MemWrite1   = 1'b0;
    MemWrite2   = 1'b0;
    MemDst1     = 2'd0;
    MemDst2     = 2'd0;
    MemData     = 2'd0;
    Halted      = 1'b0;
    IllegalOp   = 1'b0;

    // Gating on RegResetN keeps INIT's register resets (and any half-done
    // instruction's strobes) off the datapath while reset is held.
    if (RegResetN) begin
      case (state_q)
        S_INIT: begin
          PCRegReset  = 1'b1;
          MSPRegReset = 1'b1;
          RSPRegReset = 1'b1;
          state_d     = S_FETCH;
        end
        S_FETCH: begin
          if (Run) begin
            MemRead1 = 1'b1;
            IRWrite  = 1'b1;
            PCWrite  = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            4'h0:    state_d = S_FETCH;
            4'h1:    state_d = S_PUSH;
            4'h2:    state_d = S_ALU_D;
            4'h3:    state_d = S_JMP;
            4'h4:    state_d = S_CALL;
            4'h5:    state_d = S_RET_D;
            4'hF:    state_d = S_HALT;
            default: begin
              IllegalOp = 1'b1;
              state_d   = S_FETCH;
            end
          endcase
        end
        S_PUSH: begin
          MemData   = 2'd2;
          MemWrite2 = 1'b1;
          MSPWrite  = 1'b1;
          state_d   = S_FETCH;
        end
        S_ALU_D: begin
          MSPWrite = 1'b1;
          MSPop    = 1'b1;
          state_d  = S_ALU_RA;
        end
        S_ALU_RA: begin
          MemRead2  = 1'b1;
          ValAWrite = 1'b1;
          MSPWrite  = 1'b1;
          MSPop     = 1'b1;
          state_d   = S_ALU_RB;
        end
        S_ALU_RB: begin
          MemDst1   = 2'd1;
          MemRead1  = 1'b1;
          ValBWrite = 1'b1;
          state_d   = S_ALU_WB;
        end
        S_ALU_WB: begin
          MemData   = 2'd1;
          MemWrite2 = 1'b1;
          MSPWrite  = 1'b1;
          state_d   = S_FETCH;
        end
        S_JMP: begin
          PCWrite = 1'b1;
          PCAdd   = 1'b1;
          state_d = S_FETCH;
        end
        S_CALL: begin
          MemDst2   = 2'd1;
          MemWrite2 = 1'b1;
          RSPWrite  = 1'b1;
          PCWrite   = 1'b1;
          PCAdd     = 1'b1;
          state_d   = S_FETCH;
        end
        S_RET_D: begin
          RSPWrite = 1'b1;
          RSPop    = 1'b1;
          state_d  = S_RET_R;
        end
        S_RET_R: begin
          MemDst2   = 2'd1;
          MemRead2  = 1'b1;
          ValAWrite = 1'b1;
          state_d   = S_RET_J;
        end
        S_RET_J: begin
          PCWrite  = 1'b1;
          PCSource = 1'b1;
          state_d  = S_FETCH;
        end
        S_HALT: begin
          Halted = 1'b1;
        end
        default: state_d = S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jala_sequencer.sv
// Directed bench for jala_sequencer: a small behavioural datapath and memory
// around the sequencer, with per-scenario tasks checking registers, memory and timing.
module tb_jala_sequencer;

  logic        CLK, RegResetN, Run;
  logic [15:0] IROut;
  logic        MSPWrite, MSPop, MSPRegReset, RSPWrite, RSPop, RSPRegReset;
  logic        PCWrite, PCSource, PCAdd, PCRegReset;
  logic        ValAWrite, ValBWrite, IRWrite;
  logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0]  MemDst1, MemDst2, MemData;
  logic        Halted, IllegalOp;
  logic [3:0]  State;

  localparam logic [3:0] ST_INIT = 4'd0, ST_FETCH = 4'd1, ST_ALU_RA = 4'd5, ST_HALT = 4'd13;

  jala_sequencer dut (
    .CLK(CLK), .RegResetN(RegResetN), .Run(Run), .IROut(IROut),
    .MSPWrite(MSPWrite), .MSPop(MSPop), .MSPRegReset(MSPRegReset),
    .RSPWrite(RSPWrite), .RSPop(RSPop), .RSPRegReset(RSPRegReset),
    .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd), .PCRegReset(PCRegReset),
    .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .IRWrite(IRWrite),
    .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
    .Halted(Halted), .IllegalOp(IllegalOp), .State(State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural datapath model
  logic [15:0] pc, msp, rsp, val_a, val_b, ir;
  logic [15:0] mem  [0:255];
  logic [15:0] prog [0:255];
  logic [15:0] addr1, addr2, rd1, rd2, sext, zimm, res, wdata;
  logic [24:0] outs;

  assign IROut = ir;
  assign addr1 = (MemDst1 == 2'd1) ? msp : pc;
  assign addr2 = (MemDst2 == 2'd1) ? rsp : msp;
  assign rd1   = mem[addr1[7:0]];
  assign rd2   = mem[addr2[7:0]];
  assign sext  = {{4{ir[11]}}, ir[11:0]};
  assign zimm  = {4'h0, ir[11:0]};
  assign res   = val_a + val_b;
  assign wdata = (MemData == 2'd2) ? zimm : (MemData == 2'd1) ? res : pc;
  assign outs  = {MSPWrite, MSPop, MSPRegReset, RSPWrite, RSPop, RSPRegReset,
                  PCWrite, PCSource, PCAdd, PCRegReset, ValAWrite, ValBWrite, IRWrite,
                  MemRead1, MemRead2, MemWrite1, MemWrite2,
                  MemDst1, MemDst2, MemData, Halted, IllegalOp};

  // While reset is held the model reloads the program and scrambles its registers.
  always @(posedge CLK) begin
    if (!RegResetN) begin
      mem <= prog;
      pc <= 16'hbeef; msp <= 16'hbeef; rsp <= 16'hbeef;
      val_a <= 16'hdead; val_b <= 16'hdead; ir <= 16'h0000;
    end else begin
      if (PCRegReset) pc <= 16'd0;
      else if (PCWrite) pc <= PCSource ? val_a : pc + (PCAdd ? sext : 16'd1);
      if (MSPRegReset) msp <= 16'd0;
      else if (MSPWrite) msp <= MSPop ? msp - 16'd1 : msp + 16'd1;
      if (RSPRegReset) rsp <= 16'd0;
      else if (RSPWrite) rsp <= RSPop ? rsp - 16'd1 : rsp + 16'd1;
      if (ValAWrite) val_a <= rd2;
      if (ValBWrite) val_b <= rd1;
      if (IRWrite)   ir    <= rd1;
      if (MemWrite2) mem[addr2[7:0]] <= wdata;
    end
  end

  int wr2_cnt = 0, ill_cnt = 0, strobe_cnt = 0;
  always @(posedge CLK) begin
    if (MemWrite2) wr2_cnt <= wr2_cnt + 1;
    if (IllegalOp) ill_cnt <= ill_cnt + 1;
    if (outs != 25'd0) strobe_cnt <= strobe_cnt + 1;
  end

  int n_checks = 0, n_fail = 0;

  task automatic clear_prog;
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  task automatic apply_reset;
    Run = 1'b0;
    RegResetN = 1'b0;
    repeat (3) @(negedge CLK);
    RegResetN = 1'b1;
    @(negedge CLK);
  endtask

  // Executes one instruction from FETCH; cyc = edges until FETCH again, -1 on timeout.
  task automatic run_instr(output int cyc);
    Run = 1'b1;
    @(negedge CLK);
    Run = 1'b0;
    cyc = 1;
    while (State != ST_FETCH && cyc < 64) begin
      @(negedge CLK);
      cyc++;
    end
    if (State != ST_FETCH) cyc = -1;
  endtask

  task automatic test_reset;
    clear_prog();
    Run = 1'b0;
    RegResetN = 1'b1;
    #2 RegResetN = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++; if (State !== ST_INIT) begin n_fail++; $display("FAIL reset_hold_state got=%0d exp=%0d", State, ST_INIT); end
    n_checks++; if (outs !== 25'd0) begin n_fail++; $display("FAIL reset_hold_outs got=%h exp=0", outs); end
    RegResetN = 1'b1;
    #1;
    n_checks++; if (State !== ST_INIT) begin n_fail++; $display("FAIL reset_init_state got=%0d exp=%0d", State, ST_INIT); end
    n_checks++; if ({PCRegReset, MSPRegReset, RSPRegReset} !== 3'b111) begin n_fail++; $display("FAIL reset_init_resets got=%b exp=111", {PCRegReset, MSPRegReset, RSPRegReset}); end
    @(negedge CLK);
    n_checks++; if (State !== ST_FETCH) begin n_fail++; $display("FAIL reset_fetch_state got=%0d exp=%0d", State, ST_FETCH); end
    n_checks++; if ({pc, msp, rsp} !== 48'd0) begin n_fail++; $display("FAIL reset_regs got pc=%h msp=%h rsp=%h exp=0", pc, msp, rsp); end
  endtask

  task automatic test_pushi_alu;
    int c;
    clear_prog();
    prog[0] = 16'h1005; prog[1] = 16'h1003; prog[2] = 16'h2000;
    apply_reset();
    run_instr(c);
    n_checks++; if (c !== 3) begin n_fail++; $display("FAIL pushi_cycles got=%0d exp=3", c); end
    n_checks++; if (mem[0] !== 16'h0005 || msp !== 16'd1) begin n_fail++; $display("FAIL pushi_store got mem0=%h msp=%h exp 0005/0001", mem[0], msp); end
    run_instr(c);
    run_instr(c);
    n_checks++; if (c !== 6) begin n_fail++; $display("FAIL alu_cycles got=%0d exp=6", c); end
    n_checks++; if (val_a !== 16'd3 || val_b !== 16'd5) begin n_fail++; $display("FAIL alu_operands got a=%h b=%h exp 3/5", val_a, val_b); end
    n_checks++; if (mem[0] !== 16'd8 || msp !== 16'd1) begin n_fail++; $display("FAIL alu_result got mem0=%h msp=%h exp 0008/0001", mem[0], msp); end
  endtask

  task automatic test_control_flow;
    int c;
    clear_prog();
    prog[2] = 16'h4004; prog[3] = 16'h3FFD; prog[7] = 16'h5000;
    apply_reset();
    run_instr(c);
    n_checks++; if (c !== 2) begin n_fail++; $display("FAIL nop_cycles got=%0d exp=2", c); end
    run_instr(c);
    run_instr(c);
    n_checks++; if (c !== 3) begin n_fail++; $display("FAIL call_cycles got=%0d exp=3", c); end
    n_checks++; if (mem[0] !== 16'd3 || rsp !== 16'd1 || pc !== 16'd7) begin n_fail++; $display("FAIL call_state got mem0=%h rsp=%h pc=%h exp 3/1/7", mem[0], rsp, pc); end
    run_instr(c);
    n_checks++; if (c !== 5) begin n_fail++; $display("FAIL ret_cycles got=%0d exp=5", c); end
    n_checks++; if (pc !== 16'd3 || rsp !== 16'd0) begin n_fail++; $display("FAIL ret_state got pc=%h rsp=%h exp 3/0", pc, rsp); end
    run_instr(c);
    n_checks++; if (c !== 3) begin n_fail++; $display("FAIL jmp_cycles got=%0d exp=3", c); end
    n_checks++; if (pc !== 16'd1) begin n_fail++; $display("FAIL jmp_back_pc got=%h exp=0001", pc); end
  endtask

  task automatic test_stall_illegal;
    int c, s0, i0;
    clear_prog();
    prog[0] = 16'h7000;
    apply_reset();
    s0 = strobe_cnt;
    repeat (10) @(negedge CLK);
    n_checks++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL stall_strobes got=%0d exp=0", strobe_cnt - s0); end
    n_checks++; if (pc !== 16'd0 || State !== ST_FETCH) begin n_fail++; $display("FAIL stall_hold got pc=%h state=%0d exp 0/1", pc, State); end
    i0 = ill_cnt;
    run_instr(c);
    n_checks++; if (c !== 2) begin n_fail++; $display("FAIL illegal_cycles got=%0d exp=2", c); end
    n_checks++; if (ill_cnt - i0 !== 1) begin n_fail++; $display("FAIL illegal_pulse got=%0d exp=1", ill_cnt - i0); end
    n_checks++; if (pc !== 16'd1) begin n_fail++; $display("FAIL illegal_pc got=%h exp=0001", pc); end
  endtask

  task automatic test_halt;
    int good;
    clear_prog();
    prog[0] = 16'hF000;
    apply_reset();
    Run = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++; if (State !== ST_HALT || Halted !== 1'b1) begin n_fail++; $display("FAIL halt_enter got state=%0d halted=%b exp 13/1", State, Halted); end
    good = 0;
    repeat (20) begin
      @(negedge CLK);
      if (Halted === 1'b1 && State === ST_HALT) good++;
    end
    n_checks++; if (good !== 20) begin n_fail++; $display("FAIL halt_hold got=%0d exp=20", good); end
    Run = 1'b0;
  endtask

  task automatic test_async_abort;
    int c, w0;
    clear_prog();
    prog[0] = 16'h1005; prog[1] = 16'h1003; prog[2] = 16'h2000;
    apply_reset();
    run_instr(c);
    run_instr(c);
    Run = 1'b1;
    @(negedge CLK);
    Run = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    #2;
    n_checks++; if (State !== ST_ALU_RA) begin n_fail++; $display("FAIL abort_reach got=%0d exp=%0d", State, ST_ALU_RA); end
    w0 = wr2_cnt;
    RegResetN = 1'b0;
    #1;
    n_checks++; if (outs !== 25'd0 || State !== ST_INIT) begin n_fail++; $display("FAIL abort_outs got outs=%h state=%0d exp 0/0", outs, State); end
    repeat (3) @(negedge CLK);
    RegResetN = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++; if (wr2_cnt - w0 !== 0 || State !== ST_FETCH) begin n_fail++; $display("FAIL abort_no_write got writes=%0d state=%0d exp 0/1", wr2_cnt - w0, State); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pushi_alu();
    test_control_flow();
    test_stall_illegal();
    test_halt();
    test_async_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
